flit_rx_monitor: RTL and testbench

- Receive-side endpoint for the router flit interface (data/valid/vch) driven by the mux and router output ports.
- Consumes flits, checks packet framing (HEAD, DATA*, TAIL) and virtual-channel consistency.
- Reports packet count, last payload length and cumulative payload bit-toggle count for energy characterization.
- Synthesizable so it can sit after a mux/router in characterization netlists and replace testbench $write checking.

---
 rtl/flit_rx_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_flit_rx_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_rx_monitor.sv
// rtl/flit_rx_monitor.sv - flit receive endpoint: framing/vch checks, packet and payload-toggle statistics
// Optional feature macro RX_CHECKSUM_EN adds last_csum, the XOR of the last packet's DATA payloads.
`ifndef TYPE_NONE
`define TYPE_NONE 3'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'd1
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 3'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'd3
`endif

module flit_rx_monitor #(
  parameter int FLIT_W = 67,
  parameter int TYPE_W = 3,
  parameter int VCH_W  = 2,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16,
  parameter int TGL_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLIT_W-1:0]   idata,
  input  logic                ivalid,
  input  logic [VCH_W-1:0]    ivch,
  input  logic                clr_stat,
  output logic                busy,
  output logic                pkt_done,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [LEN_W-1:0]    last_len,
  output logic [TGL_W-1:0]    toggle_cnt,
  output logic                err_head,
  output logic                err_orphan,
  output logic                err_vch
`ifdef RX_CHECKSUM_EN
  ,
  output logic [FLIT_W-TYPE_W-1:0] last_csum
`endif
);
  localparam int PAY_W = FLIT_W - TYPE_W;
  localparam int POP_W = $clog2(PAY_W + 1);

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [VCH_W-1:0]    cur_vch_q, cur_vch_d;
  logic [PAY_W-1:0]    prev_payload_q, prev_payload_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [LEN_W-1:0]    last_len_q, last_len_d;
  logic [TGL_W-1:0]    toggle_cnt_q, toggle_cnt_d;
  logic                err_head_q, err_head_d;
  logic                err_orphan_q, err_orphan_d;
  logic                err_vch_q, err_vch_d;
  logic                pkt_done_q, pkt_done_d;
`ifdef RX_CHECKSUM_EN
  logic [PAY_W-1:0]    csum_q, csum_d;
  logic [PAY_W-1:0]    last_csum_q, last_csum_d;
`endif

  logic [TYPE_W-1:0]   ftype;
  logic [PAY_W-1:0]    payload;
  logic                accept;
  logic [POP_W-1:0]    flips;
  logic [TGL_W:0]      tgl_sum;

  function automatic logic [POP_W-1:0] popcount(input logic [PAY_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < PAY_W; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  assign ftype   = idata[FLIT_W-1 -: TYPE_W];
  assign payload = idata[PAY_W-1:0];
  assign accept  = ivalid && (ftype != `TYPE_NONE);
  assign flips   = popcount(payload ^ prev_payload_q);
  assign tgl_sum = {1'b0, toggle_cnt_q} + (TGL_W+1)'(flips);

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    cur_vch_d      = cur_vch_q;
    prev_payload_d = prev_payload_q;
    pkt_cnt_d      = pkt_cnt_q;
    last_len_d     = last_len_q;
    toggle_cnt_d   = toggle_cnt_q;
    err_head_d     = err_head_q;
    err_orphan_d   = err_orphan_q;
    err_vch_d      = err_vch_q;
    pkt_done_d     = 1'b0;
`ifdef RX_CHECKSUM_EN
    csum_d         = csum_q;
    last_csum_d    = last_csum_q;
`endif
    if (accept) begin
      prev_payload_d = payload;
      toggle_cnt_d   = tgl_sum[TGL_W] ? '1 : tgl_sum[TGL_W-1:0];
      case (state_q)
        ST_IDLE: begin
          if (ftype == `TYPE_HEAD) begin
            state_d   = ST_BODY;
            len_d     = '0;
            cur_vch_d = ivch;
`ifdef RX_CHECKSUM_EN
            csum_d    = '0;
`endif
          end else if (ftype == `TYPE_DATA || ftype == `TYPE_TAIL) begin
            err_orphan_d = 1'b1;
          end
        end
        ST_BODY: begin
          if ((ftype == `TYPE_DATA || ftype == `TYPE_TAIL) && ivch != cur_vch_q)
            err_vch_d = 1'b1;
          if (ftype == `TYPE_HEAD) begin
            // A second HEAD abandons the open packet and starts a fresh one.
            err_head_d = 1'b1;
            len_d      = '0;
            cur_vch_d  = ivch;
`ifdef RX_CHECKSUM_EN
            csum_d     = '0;
`endif
          end else if (ftype == `TYPE_DATA) begin
            if (len_q != '1) len_d = len_q + LEN_W'(1);
`ifdef RX_CHECKSUM_EN
            csum_d = csum_q ^ payload;
`endif
          end else if (ftype == `TYPE_TAIL) begin
            last_len_d = len_q;
            if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            pkt_done_d = 1'b1;
            state_d    = ST_IDLE;
`ifdef RX_CHECKSUM_EN
            last_csum_d = csum_q;
`endif
          end
        end
      endcase
    end
    if (clr_stat) begin
      pkt_cnt_d    = '0;
      last_len_d   = '0;
      toggle_cnt_d = '0;
      err_head_d   = 1'b0;
      err_orphan_d = 1'b0;
      err_vch_d    = 1'b0;
`ifdef RX_CHECKSUM_EN
      last_csum_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      cur_vch_q      <= '0;
      prev_payload_q <= '0;
      pkt_cnt_q      <= '0;
      last_len_q     <= '0;
      toggle_cnt_q   <= '0;
      err_head_q     <= 1'b0;
      err_orphan_q   <= 1'b0;
      err_vch_q      <= 1'b0;
      pkt_done_q     <= 1'b0;
`ifdef RX_CHECKSUM_EN
      csum_q         <= '0;
      last_csum_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cur_vch_q      <= cur_vch_d;
      prev_payload_q <= prev_payload_d;
      pkt_cnt_q      <= pkt_cnt_d;
      last_len_q     <= last_len_d;
      toggle_cnt_q   <= toggle_cnt_d;
      err_head_q     <= err_head_d;
      err_orphan_q   <= err_orphan_d;
      err_vch_q      <= err_vch_d;
      pkt_done_q     <= pkt_done_d;
`ifdef RX_CHECKSUM_EN
      csum_q         <= csum_d;
      last_csum_q    <= last_csum_d;
`endif
    end
  end

  assign busy       = (state_q == ST_BODY);
  assign pkt_done   = pkt_done_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign last_len   = last_len_q;
  assign toggle_cnt = toggle_cnt_q;
  assign err_head   = err_head_q;
  assign err_orphan = err_orphan_q;
  assign err_vch    = err_vch_q;
`ifdef RX_CHECKSUM_EN
  assign last_csum  = last_csum_q;
`endif

endmodule

// File: tb/tb_flit_rx_monitor.sv
// tb/tb_flit_rx_monitor.sv - directed and randomized bench for flit_rx_monitor against a packet-level model
module tb_flit_rx_monitor;
  localparam int FLIT_W = 67;
  localparam int TYPE_W = 3;
  localparam int VCH_W  = 2;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 16;
  localparam int TGL_W  = 32;
  localparam logic [2:0] T_NONE = 3'd0, T_HEAD = 3'd1, T_DATA = 3'd2, T_TAIL = 3'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLIT_W-1:0] idata = '0;
  logic              ivalid = 1'b0;
  logic [VCH_W-1:0]  ivch = '0;
  logic              clr_stat = 1'b0;
  logic              busy, pkt_done, err_head, err_orphan, err_vch;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [LEN_W-1:0]  last_len;
  logic [TGL_W-1:0]  toggle_cnt;
`ifdef RX_CHECKSUM_EN
  logic [63:0]       last_csum;
`endif

  flit_rx_monitor dut (
    .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr_stat(clr_stat),
    .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt), .last_len(last_len),
    .toggle_cnt(toggle_cnt), .err_head(err_head), .err_orphan(err_orphan), .err_vch(err_vch)
`ifdef RX_CHECKSUM_EN
    , .last_csum(last_csum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level reference: an open flag plus the list of DATA payloads of the open packet.
  bit          m_open;
  logic [1:0]  m_vch;
  logic [63:0] m_pkt[$];
  logic [63:0] m_prev;
  longint      m_pkts, m_tgl;
  int          m_last_len;
  bit          m_eh, m_eo, m_ev, m_done;
  logic [63:0] m_csum;

  function automatic void model_reset();
    m_open = 0; m_vch = 0; m_pkt.delete(); m_prev = 0; m_pkts = 0; m_tgl = 0;
    m_last_len = 0; m_eh = 0; m_eo = 0; m_ev = 0; m_done = 0; m_csum = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [2:0] t, input logic [1:0] vc,
                                     input logic [63:0] p, input bit c);
    m_done = 0;
    if (v && t != T_NONE) begin
      m_tgl = m_tgl + $countones(p ^ m_prev);
      if (m_tgl > 64'hFFFF_FFFF) m_tgl = 64'hFFFF_FFFF;
      m_prev = p;
      if (!m_open) begin
        if (t == T_HEAD) begin m_open = 1; m_vch = vc; m_pkt.delete(); end
        else m_eo = 1;
      end else begin
        if (t != T_HEAD && vc != m_vch) m_ev = 1;
        if (t == T_HEAD) begin
          m_eh = 1; m_vch = vc; m_pkt.delete();
        end else if (t == T_DATA) begin
          m_pkt.push_back(p);
        end else begin
          m_last_len = (m_pkt.size() > 255) ? 255 : m_pkt.size();
          m_pkts = (m_pkts < 65535) ? m_pkts + 1 : 65535;
          m_csum = 0;
          foreach (m_pkt[i]) m_csum = m_csum ^ m_pkt[i];
          m_done = 1; m_open = 0;
        end
      end
    end
    if (c) begin
      m_pkts = 0; m_last_len = 0; m_tgl = 0; m_eh = 0; m_eo = 0; m_ev = 0; m_csum = 0;
    end
  endfunction

  task automatic check_all();
    if (pkt_done === 1'b1) done_seen++;
    check("busy", busy, m_open);
    check("pkt_done", pkt_done, m_done);
    check("pkt_cnt", pkt_cnt, m_pkts);
    check("last_len", last_len, m_last_len);
    check("toggle_cnt", toggle_cnt, m_tgl);
    check("err_head", err_head, m_eh);
    check("err_orphan", err_orphan, m_eo);
    check("err_vch", err_vch, m_ev);
`ifdef RX_CHECKSUM_EN
    check("last_csum", last_csum, m_csum);
`endif
  endtask

  task automatic step(input bit v, input logic [2:0] t, input logic [1:0] vc,
                      input logic [63:0] p, input bit c);
    @(negedge clk);
    ivalid = v; idata = {t, p}; ivch = vc; clr_stat = c;
    @(posedge clk);
    model_step(v, t, vc, p, c);
    #1 check_all();
  endtask

  task automatic flit(input logic [2:0] t, input logic [1:0] vc, input logic [63:0] p);
    step(1'b1, t, vc, p, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, T_DATA, 2'd0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
  endtask

  // Asserts reset between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ivalid = 1'b0; clr_stat = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] ones;
    ones = '1;
    do_reset();

    // Back-to-back well-formed packets.
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      flit(T_HEAD, 2'd0, {$urandom, $urandom});
      for (int d = 0; d < 20; d++) flit(T_DATA, 2'd0, {$urandom, $urandom});
      flit(T_TAIL, 2'd0, {$urandom, $urandom});
      for (int g = 0; g < 7; g++) begin
        idle();
        check("gap_busy", busy, 1'b0);
      end
    end
    check("s1_pulses", done_seen, 10);
    check("s1_pkt_cnt", pkt_cnt, 10);
    check("s1_last_len", last_len, 20);
    check("s1_errs", {err_head, err_orphan, err_vch}, 3'b000);

    // All-ones payload flips every bit twice.
    do_reset();
    flit(T_HEAD, 2'd0, 64'd0);
    flit(T_DATA, 2'd0, ones);
    flit(T_TAIL, 2'd0, 64'd0);
    check("s2_toggle", toggle_cnt, 128);
    check("s2_last_len", last_len, 1);

    // Orphans while idle, then a valid packet; orphan flag is sticky until clr_stat.
    do_reset();
    flit(T_DATA, 2'd0, 64'h0000_0000_0000_00FF);
    flit(T_TAIL, 2'd0, 64'h0000_0000_0000_0F0F);
    check("s3_orphan", err_orphan, 1'b1);
    check("s3_pkt_cnt0", pkt_cnt, 0);
    check("s3_toggle", toggle_cnt, 8 + 8);
    flit(T_HEAD, 2'd0, 64'd0);
    flit(T_DATA, 2'd0, 64'd0);
    flit(T_TAIL, 2'd0, 64'd0);
    check("s3_pkt_cnt1", pkt_cnt, 1);
    check("s3_orphan_sticky", err_orphan, 1'b1);
    step(1'b0, T_NONE, 2'd0, 64'd0, 1'b1);
    check("s3_orphan_clr", err_orphan, 1'b0);

    // HEAD inside an open packet aborts it.
    do_reset();
    flit(T_HEAD, 2'd0, 64'd1);
    for (int d = 0; d < 3; d++) flit(T_DATA, 2'd0, 64'd2);
    flit(T_HEAD, 2'd0, 64'd3);
    for (int d = 0; d < 2; d++) flit(T_DATA, 2'd0, 64'd4);
    flit(T_TAIL, 2'd0, 64'd5);
    check("s4_err_head", err_head, 1'b1);
    check("s4_pkt_cnt", pkt_cnt, 1);
    check("s4_last_len", last_len, 2);

    // VC mismatch, then TAIL coinciding with clr_stat.
    do_reset();
    flit(T_HEAD, 2'd1, 64'd0);
    flit(T_DATA, 2'd2, 64'd0);
    check("s5_err_vch", err_vch, 1'b1);
    flit(T_TAIL, 2'd1, 64'd0);
    check("s5_last_len", last_len, 1);
    flit(T_HEAD, 2'd1, 64'd0);
    step(1'b1, T_TAIL, 2'd1, 64'd0, 1'b1);
    check("s5_clr_pkt_cnt", pkt_cnt, 0);
    check("s5_clr_done", pkt_done, 1'b1);

    // Reset mid-packet discards it.
    do_reset();
    flit(T_HEAD, 2'd0, 64'd0);
    for (int d = 0; d < 5; d++) flit(T_DATA, 2'd0, 64'd7);
    do_reset();
    check("s6_busy", busy, 1'b0);
    flit(T_TAIL, 2'd0, 64'd0);
    check("s6_orphan", err_orphan, 1'b1);
    check("s6_pkt_cnt", pkt_cnt, 0);
`ifdef RX_CHECKSUM_EN
    flit(T_HEAD, 2'd0, 64'h55);
    flit(T_DATA, 2'd0, 64'h0F);
    flit(T_DATA, 2'd0, 64'hF0);
    flit(T_DATA, 2'd0, 64'hFF);
    flit(T_TAIL, 2'd0, 64'h0);
    check("s6_csum", last_csum, 64'h0);
`endif

    // Length counter saturation.
    do_reset();
    flit(T_HEAD, 2'd3, 64'd0);
    for (int d = 0; d < 300; d++) flit(T_DATA, 2'd3, {$urandom, $urandom});
    flit(T_TAIL, 2'd3, 64'd0);
    check("len_sat", last_len, 255);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [2:0] t;
      logic [1:0] vc;
      if ($urandom_range(0, 599) == 0) do_reset();
      r = $urandom_range(0, 9);
      t = (r == 0) ? T_NONE : (r == 1) ? T_HEAD : (r <= 7) ? T_DATA : T_TAIL;
      vc = ($urandom_range(0, 9) < 8) ? m_vch : 2'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 8, t, vc, {$urandom, $urandom}, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
